// File: rtl/blit_pkg.sv
// Shared types and constants for the blitter rectangle scan stage.
// Provides the scan FSM state encoding, the default coordinate width
// and the coordinate typedef used by the scan logic and its users.
package blit_pkg;

   localparam int BLIT_CW = 16;

   typedef logic [BLIT_CW-1:0] blit_coord_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } blit_scan_state_t;

endpackage

// File: rtl/blit_rect_scan_if.sv
// Command/pixel bus of the rectangle scan generator.
// master: drives stall, the start command and its operands; sees busy/p2_*/done.
// slave : the scan generator. Macro BLIT_CLIP_EN adds the clip box operands.
interface blit_rect_scan_if
   import blit_pkg::*;
#(
   parameter int CW = BLIT_CW
);

   logic          stall;
   logic          start;
   logic          x_rev;
   logic          y_rev;
   logic [CW-1:0] width;
   logic [CW-1:0] height;
   logic [CW-1:0] dest_x;
   logic [CW-1:0] dest_y;
   logic [CW-1:0] src_x;
   logic [CW-1:0] src_y;
`ifdef BLIT_CLIP_EN
   logic [CW-1:0] clip_x1;
   logic [CW-1:0] clip_y1;
   logic [CW-1:0] clip_x2;
   logic [CW-1:0] clip_y2;
`endif
   logic          busy;
   logic          p2_valid;
   logic          p2_last;
   logic [CW-1:0] p2_dest_x;
   logic [CW-1:0] p2_dest_y;
   logic [CW-1:0] p2_src_x;
   logic [CW-1:0] p2_src_y;
   logic          done;

   modport master (
      output stall, start, x_rev, y_rev, width, height,
             dest_x, dest_y, src_x, src_y,
`ifdef BLIT_CLIP_EN
      output clip_x1, clip_y1, clip_x2, clip_y2,
`endif
      input  busy, p2_valid, p2_last, p2_dest_x, p2_dest_y,
             p2_src_x, p2_src_y, done
   );

   modport slave (
      input  stall, start, x_rev, y_rev, width, height,
             dest_x, dest_y, src_x, src_y,
`ifdef BLIT_CLIP_EN
      input  clip_x1, clip_y1, clip_x2, clip_y2,
`endif
      output busy, p2_valid, p2_last, p2_dest_x, p2_dest_y,
             p2_src_x, p2_src_y, done
   );

endinterface

// File: rtl/blit_axis_step.sv
// One scan axis: offset counter, terminal-count compare, dest/src base +/- offset.
// Ports: clock/reset/stall; load_i latches size/rev/bases and clears the counter;
// step_i advances (wrapping at size-1); tc_o, dest_o, src_o are combinational.
module blit_axis_step
   import blit_pkg::*;
#(
   parameter int CW    = BLIT_CW,
   parameter int CNT_W = CW
)(
   input  logic          clock,
   input  logic          reset,
   input  logic          stall,
   input  logic          load_i,
   input  logic          step_i,
   input  logic          rev_i,
   input  logic [CW-1:0] size_i,
   input  logic [CW-1:0] dest_base_i,
   input  logic [CW-1:0] src_base_i,
   output logic          tc_o,
   output logic [CW-1:0] dest_o,
   output logic [CW-1:0] src_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CW-1:0]    size_q, dest_base_q, src_base_q;
   logic             rev_q;
   logic [CW-1:0]    off;

   // Compare against the latched size only; a zero size never reaches RUN.
   assign tc_o = (cnt_q == (CNT_W'(size_q) - CNT_W'(1)));
   assign off  = cnt_q[CW-1:0];

   // Arithmetic wraps modulo 2^CW by construction.
   assign dest_o = rev_q ? (dest_base_q - off) : (dest_base_q + off);
   assign src_o  = rev_q ? (src_base_q  - off) : (src_base_q  + off);

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = '0;
      else if (step_i)
         cnt_d = tc_o ? '0 : (cnt_q + CNT_W'(1));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q       <= '0;
         size_q      <= '0;
         dest_base_q <= '0;
         src_base_q  <= '0;
         rev_q       <= 1'b0;
      end else if (!stall) begin
         cnt_q <= cnt_d;
         if (load_i) begin
            size_q      <= size_i;
            dest_base_q <= dest_base_i;
            src_base_q  <= src_base_i;
            rev_q       <= rev_i;
         end
      end
   end

endmodule

// File: rtl/blit_rect_scan.sv
// Rectangle scan generator: walks WIDTH x HEIGHT (x inner, y outer) emitting dest/src pairs.
// Ports: clock, reset (sync, active-high), bus (slave modport of blit_rect_scan_if).
// Optional macro BLIT_CLIP_EN: latched inclusive clip box masks p2_valid on dest.
module blit_rect_scan
   import blit_pkg::*;
#(
   parameter int CW    = BLIT_CW,
   parameter int CNT_W = CW
)(
   input  logic                clock,
   input  logic                reset,
   blit_rect_scan_if.slave     bus
);

   blit_scan_state_t state_q, state_d;

   logic          load;
   logic          run;
   logic          x_tc, y_tc;
   logic [CW-1:0] dx, dy, sx, sy;
   logic [CW-1:0] hold_dx_q, hold_dy_q, hold_sx_q, hold_sy_q;
   logic          in_box;

   assign run  = (state_q == RUN);
   // Operands are latched whenever IDLE sees start; the axes gate on stall themselves.
   assign load = (state_q == IDLE) && bus.start;

   blit_axis_step #(.CW(CW), .CNT_W(CNT_W)) u_x (
      .clock(clock), .reset(reset), .stall(bus.stall),
      .load_i(load), .step_i(run), .rev_i(bus.x_rev),
      .size_i(bus.width), .dest_base_i(bus.dest_x), .src_base_i(bus.src_x),
      .tc_o(x_tc), .dest_o(dx), .src_o(sx)
   );

   blit_axis_step #(.CW(CW), .CNT_W(CNT_W)) u_y (
      .clock(clock), .reset(reset), .stall(bus.stall),
      .load_i(load), .step_i(run && x_tc), .rev_i(bus.y_rev),
      .size_i(bus.height), .dest_base_i(bus.dest_y), .src_base_i(bus.src_y),
      .tc_o(y_tc), .dest_o(dy), .src_o(sy)
   );

   // State register
   always_ff @(posedge clock) begin
      if (reset)
         state_q <= IDLE;
      else if (!bus.stall)
         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.start)
               state_d = ((bus.width == '0) || (bus.height == '0)) ? FLUSH : RUN;
         end
         RUN: begin
            if (x_tc && y_tc)
               state_d = FLUSH;
         end
         FLUSH:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Coordinates seen outside RUN are those of the last scanned position.
   always_ff @(posedge clock) begin
      if (reset) begin
         hold_dx_q <= '0;
         hold_dy_q <= '0;
         hold_sx_q <= '0;
         hold_sy_q <= '0;
      end else if (!bus.stall && run) begin
         hold_dx_q <= dx;
         hold_dy_q <= dy;
         hold_sx_q <= sx;
         hold_sy_q <= sy;
      end
   end

`ifdef BLIT_CLIP_EN
   logic [CW-1:0] clip_x1_q, clip_y1_q, clip_x2_q, clip_y2_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         clip_x1_q <= '0;
         clip_y1_q <= '0;
         clip_x2_q <= '0;
         clip_y2_q <= '0;
      end else if (!bus.stall && load) begin
         clip_x1_q <= bus.clip_x1;
         clip_y1_q <= bus.clip_y1;
         clip_x2_q <= bus.clip_x2;
         clip_y2_q <= bus.clip_y2;
      end
   end

   assign in_box = (dx >= clip_x1_q) && (dx <= clip_x2_q) &&
                   (dy >= clip_y1_q) && (dy <= clip_y2_q);
`else
   assign in_box = 1'b1;
`endif

   // Output logic
   always_comb begin
      bus.busy      = (state_q != IDLE);
      bus.p2_valid  = run && in_box;
      bus.p2_last   = run && x_tc && y_tc;
      bus.done      = (state_q == FLUSH);
      bus.p2_dest_x = run ? dx : hold_dx_q;
      bus.p2_dest_y = run ? dy : hold_dy_q;
      bus.p2_src_x  = run ? sx : hold_sx_q;
      bus.p2_src_y  = run ? sy : hold_sy_q;
   end

endmodule

// File: tb/tb_blit_rect_scan.sv
// Randomized bench for blit_rect_scan against a pixel-list reference model.
// Ports: none; instantiates blit_rect_scan_if and the DUT, clock period 10.
// With BLIT_CLIP_EN the model filters p2_valid by the dest clip box.
module tb_blit_rect_scan;
   import blit_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   blit_rect_scan_if #(.CW(BLIT_CW)) bus ();

   blit_rect_scan #(.CW(BLIT_CW), .CNT_W(BLIT_CW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct {
      blit_coord_t dx, dy, sx, sy;
      bit          last;
      bit          vld;
   } pix_t;

   int checks   = 0;
   int failures = 0;

   // Coordinates the outputs must show outside RUN.
   blit_coord_t hold_dx, hold_dy, hold_sx, hold_sy;

   task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
      end
   endtask

   function automatic logic [71:0] obs();
      return {4'h0, bus.busy, bus.p2_valid, bus.p2_last, bus.done,
              bus.p2_dest_x, bus.p2_dest_y, bus.p2_src_x, bus.p2_src_y};
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_busy"},  72'(bus.busy), 72'(0));
      check({tag, "_valid"}, 72'(bus.p2_valid), 72'(0));
      check({tag, "_last"},  72'(bus.p2_last), 72'(0));
      check({tag, "_done"},  72'(bus.done), 72'(0));
      check({tag, "_coord"}, 72'({bus.p2_dest_x, bus.p2_dest_y, bus.p2_src_x, bus.p2_src_y}),
            72'({hold_dx, hold_dy, hold_sx, hold_sy}));
   endtask

   task automatic run_cmd(input string tag, input int w, input int h,
                          input blit_coord_t dx0, input blit_coord_t dy0,
                          input blit_coord_t sx0, input blit_coord_t sy0,
                          input bit xr, input bit yr, input int stall_pct, input bit poke,
                          input blit_coord_t cx1, input blit_coord_t cy1,
                          input blit_coord_t cx2, input blit_coord_t cy2);
      pix_t        exp_q[$];
      pix_t        p;
      int          n, k, cyc, budget;
      bit          stalled, fin;
      logic [71:0] snap;
      exp_q = {};
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x++) begin
            p.dx   = xr ? blit_coord_t'(dx0 - x) : blit_coord_t'(dx0 + x);
            p.sx   = xr ? blit_coord_t'(sx0 - x) : blit_coord_t'(sx0 + x);
            p.dy   = yr ? blit_coord_t'(dy0 - y) : blit_coord_t'(dy0 + y);
            p.sy   = yr ? blit_coord_t'(sy0 - y) : blit_coord_t'(sy0 + y);
            p.last = (x == w - 1) && (y == h - 1);
`ifdef BLIT_CLIP_EN
            p.vld  = (p.dx >= cx1) && (p.dx <= cx2) && (p.dy >= cy1) && (p.dy <= cy2);
`else
            p.vld  = 1'b1 || (cx1 > cx2) || (cy1 > cy2);
`endif
            exp_q.push_back(p);
         end
      end
      n = exp_q.size();

      @(negedge clock);
      bus.width  = blit_coord_t'(w);
      bus.height = blit_coord_t'(h);
      bus.dest_x = dx0; bus.dest_y = dy0;
      bus.src_x  = sx0; bus.src_y  = sy0;
      bus.x_rev  = xr;  bus.y_rev  = yr;
`ifdef BLIT_CLIP_EN
      bus.clip_x1 = cx1; bus.clip_y1 = cy1;
      bus.clip_x2 = cx2; bus.clip_y2 = cy2;
`endif
      bus.stall = 1'b0;
      bus.start = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;

      k = 0; cyc = 0; stalled = 1'b0; fin = 1'b0; snap = '0;
      budget = (n + 2) * 20 + 10;
      while (!fin && cyc < budget) begin
         if (stalled) begin
            check({tag, "_frozen"}, obs(), snap);
         end else if (k < n) begin
            check({tag, "_valid"}, 72'(bus.p2_valid), 72'(exp_q[k].vld));
            check({tag, "_last"},  72'(bus.p2_last), 72'(exp_q[k].last));
            check({tag, "_busy"},  72'(bus.busy), 72'(1));
            check({tag, "_done"},  72'(bus.done), 72'(0));
            check({tag, "_coord"},
                  72'({bus.p2_dest_x, bus.p2_dest_y, bus.p2_src_x, bus.p2_src_y}),
                  72'({exp_q[k].dx, exp_q[k].dy, exp_q[k].sx, exp_q[k].sy}));
            hold_dx = exp_q[k].dx; hold_dy = exp_q[k].dy;
            hold_sx = exp_q[k].sx; hold_sy = exp_q[k].sy;
            k++;
         end else begin
            check({tag, "_fl_done"},  72'(bus.done), 72'(1));
            check({tag, "_fl_busy"},  72'(bus.busy), 72'(1));
            check({tag, "_fl_valid"}, 72'(bus.p2_valid), 72'(0));
            check({tag, "_fl_last"},  72'(bus.p2_last), 72'(0));
            check({tag, "_fl_coord"},
                  72'({bus.p2_dest_x, bus.p2_dest_y, bus.p2_src_x, bus.p2_src_y}),
                  72'({hold_dx, hold_dy, hold_sx, hold_sy}));
            fin = 1'b1;
         end
         snap = obs();
         if (fin) begin
            stalled   = 1'b0;
            bus.stall = 1'b0;
         end else begin
            stalled   = ($urandom_range(0, 99) < stall_pct);
            bus.stall = stalled;
         end
         if (poke) begin
            // Live operand changes and stray starts while busy must not matter.
            bus.dest_x = blit_coord_t'($urandom); bus.dest_y = blit_coord_t'($urandom);
            bus.src_x  = blit_coord_t'($urandom); bus.src_y  = blit_coord_t'($urandom);
            bus.width  = blit_coord_t'($urandom_range(0, 7));
            bus.height = blit_coord_t'($urandom_range(0, 7));
            bus.x_rev  = 1'($urandom); bus.y_rev = 1'($urandom);
            bus.start  = fin ? 1'b0 : 1'($urandom);
         end
         @(negedge clock);
         cyc++;
      end
      bus.start = 1'b0;
      if (!fin) check({tag, "_timeout"}, 72'(0), 72'(1));
      check_idle({tag, "_after"});
   endtask

   initial begin
      blit_coord_t rx, ry;
      hold_dx = '0; hold_dy = '0; hold_sx = '0; hold_sy = '0;
      bus.stall = 1'b0; bus.start = 1'b0; bus.x_rev = 1'b0; bus.y_rev = 1'b0;
      bus.width = '0; bus.height = '0;
      bus.dest_x = '0; bus.dest_y = '0; bus.src_x = '0; bus.src_y = '0;
`ifdef BLIT_CLIP_EN
      bus.clip_x1 = '0; bus.clip_y1 = '0; bus.clip_x2 = '0; bus.clip_y2 = '0;
`endif
      reset = 1'b1;
      repeat (3) @(negedge clock);
      check("reset_outputs", obs(), 72'(0));
      reset = 1'b0;
      @(negedge clock);
      check_idle("idle");

      run_cmd("fwd3x2", 3, 2, 16'd10, 16'd20, 16'd100, 16'd200, 0, 0, 0, 0,
              16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF);
      run_cmd("rev2x2", 2, 2, 16'd5, 16'd5, 16'd50, 16'd60, 1, 1, 0, 0,
              16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF);
      run_cmd("wrap", 2, 1, 16'd0, 16'd0, 16'd0, 16'd0, 1, 0, 0, 0,
              16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF);
      check("wrap_dest_x", 72'(hold_dx), 72'(16'hFFFF));
      run_cmd("stall4x1", 4, 1, 16'd7, 16'd3, 16'd70, 16'd30, 0, 0, 50, 0,
              16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF);
      run_cmd("w0", 0, 3, 16'd1, 16'd2, 16'd3, 16'd4, 0, 0, 0, 0,
              16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF);
      run_cmd("h0", 3, 0, 16'd1, 16'd2, 16'd3, 16'd4, 0, 0, 0, 0,
              16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF);
      run_cmd("one", 1, 1, 16'd9, 16'd8, 16'd7, 16'd6, 0, 1, 0, 0,
              16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF);
`ifdef BLIT_CLIP_EN
      run_cmd("clip", 4, 4, 16'd0, 16'd0, 16'd40, 16'd40, 0, 0, 0, 0,
              16'd1, 16'd1, 16'd2, 16'd2);
`endif

      for (int i = 0; i < 24; i++) begin
         rx = ($urandom_range(0, 1) == 1) ? blit_coord_t'($urandom_range(0, 3))
                                          : blit_coord_t'(16'hFFFF - $urandom_range(0, 3));
         ry = blit_coord_t'($urandom);
         run_cmd("rand", $urandom_range(0, 6), $urandom_range(0, 5), rx, ry,
                 blit_coord_t'($urandom), blit_coord_t'($urandom),
                 1'($urandom), 1'($urandom), 30, 1,
                 blit_coord_t'($urandom_range(0, 4)), blit_coord_t'($urandom_range(0, 4)),
                 blit_coord_t'($urandom_range(2, 16'hFFFF)),
                 blit_coord_t'($urandom_range(2, 16'hFFFF)));
      end

      // Reset in the middle of a scan: straight back to IDLE, no done pulse.
      @(negedge clock);
      bus.width = 16'd5; bus.height = 16'd5;
      bus.dest_x = 16'd30; bus.dest_y = 16'd40; bus.src_x = 16'd1; bus.src_y = 16'd2;
      bus.x_rev = 1'b0; bus.y_rev = 1'b0; bus.stall = 1'b0; bus.start = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
      check("mid_busy", 72'(bus.busy), 72'(1));
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      hold_dx = '0; hold_dy = '0; hold_sx = '0; hold_sy = '0;
      check_idle("mid_reset");
      reset = 1'b0;
      @(negedge clock);
      check_idle("post_reset");
      @(negedge clock);
      check_idle("post_reset2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
